// File: rtl/histogram_median_if.sv
// Handshake and result bundle between the projection-histogram engine and the
// median block; the slave modport is the median block's view.
interface histogram_median_if #(
  parameter int BINW = 8
);
  logic            start;
  logic            readHistogram;
  logic [BINW-1:0] xHistogramIn;
  logic            xValid;
  logic [BINW-1:0] yHistogramIn;
  logic            yValid;
  logic [7:0]      xMedian;
  logic [7:0]      yMedian;
  logic            histEmpty;
  logic            medianValid;
  logic            busy;

  modport master (
    output start, xHistogramIn, xValid, yHistogramIn, yValid,
    input  readHistogram, xMedian, yMedian, histEmpty, medianValid, busy
  );

  modport slave (
    input  start, xHistogramIn, xValid, yHistogramIn, yValid,
    output readHistogram, xMedian, yMedian, histEmpty, medianValid, busy
  );
endinterface

// File: rtl/histogram_median.sv
// Captures one x/y projection-histogram readout and reports the median column
// and row of the event image after a fixed-length parallel scan.
module histogram_median #(
  parameter int IMWIDTH  = 240,
  parameter int IMHEIGHT = 180,
  parameter int BINW     = 8,
  parameter int SUMW     = 16,
  parameter int TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  histogram_median_if.slave  bus
);

  localparam int MAXDIM = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
  localparam int CW     = $clog2(MAXDIM + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, CAPTURE, SCAN, DONE} state_e;

  state_e state_q, state_d;

  logic [BINW-1:0] xbuf_q [IMWIDTH];
  logic [BINW-1:0] ybuf_q [IMHEIGHT];

  logic [CW-1:0]   nx_q, nx_d, ny_q, ny_d, s_q, s_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [SUMW-1:0] xtotal_q, xtotal_d, ytotal_q, ytotal_d;
  logic [SUMW:0]   xcum_q, xcum_d, ycum_q, ycum_d;
  logic            xfound_q, xfound_d, yfound_q, yfound_d;
  logic [7:0]      xmed_scan_q, xmed_scan_d, ymed_scan_q, ymed_scan_d;
  logic [7:0]      xmedian_q, xmedian_d, ymedian_q, ymedian_d;
  logic            hist_empty_q, hist_empty_d;

  logic            x_store, y_store, capture_done, scan_last;
  logic            x_hit, y_hit;
  logic [BINW-1:0] x_bin, y_bin;
  logic [SUMW:0]   x_cum_next, y_cum_next;
  logic            read_hist, median_valid, busy;

  assign x_store = (state_q == CAPTURE) && bus.xValid && (nx_q < CW'(IMWIDTH));
  assign y_store = (state_q == CAPTURE) && bus.yValid && (ny_q < CW'(IMHEIGHT));

  // The timeout is checked on the registered count, so a beat arriving in the
  // expiry cycle is still stored on the same edge that leaves CAPTURE.
  assign capture_done = ((nx_q == CW'(IMWIDTH)) && (ny_q == CW'(IMHEIGHT))) ||
                        (idle_q == TW'(TIMEOUT));
  assign scan_last    = (s_q == CW'(MAXDIM - 1));

  // Bins past the captured count read as zero, masking stale buffer contents.
  assign x_bin = (s_q < nx_q) ? xbuf_q[s_q] : '0;
  assign y_bin = (s_q < ny_q) ? ybuf_q[s_q] : '0;

  assign x_cum_next = xcum_q + (SUMW+1)'(x_bin);
  assign y_cum_next = ycum_q + (SUMW+1)'(y_bin);
  assign x_hit      = {x_cum_next, 1'b0} >= {2'b00, xtotal_q};
  assign y_hit      = {y_cum_next, 1'b0} >= {2'b00, ytotal_q};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = REQ;
      REQ:     state_d = CAPTURE;
      CAPTURE: if (capture_done) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_hist    = (state_q == REQ);
    median_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
  end

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nx_d         = nx_q;
    ny_d         = ny_q;
    s_d          = s_q;
    idle_d       = idle_q;
    xtotal_d     = xtotal_q;
    ytotal_d     = ytotal_q;
    xcum_d       = xcum_q;
    ycum_d       = ycum_q;
    xfound_d     = xfound_q;
    yfound_d     = yfound_q;
    xmed_scan_d  = xmed_scan_q;
    ymed_scan_d  = ymed_scan_q;
    xmedian_d    = xmedian_q;
    ymedian_d    = ymedian_q;
    hist_empty_d = hist_empty_q;
    unique case (state_q)
      REQ: begin
        nx_d        = '0;
        ny_d        = '0;
        s_d         = '0;
        idle_d      = '0;
        xtotal_d    = '0;
        ytotal_d    = '0;
        xcum_d      = '0;
        ycum_d      = '0;
        xfound_d    = 1'b0;
        yfound_d    = 1'b0;
        xmed_scan_d = '0;
        ymed_scan_d = '0;
      end
      CAPTURE: begin
        if (x_store) begin
          nx_d     = nx_q + 1'b1;
          xtotal_d = xtotal_q + SUMW'(bus.xHistogramIn);
        end
        if (y_store) begin
          ny_d     = ny_q + 1'b1;
          ytotal_d = ytotal_q + SUMW'(bus.yHistogramIn);
        end
        if (bus.xValid || bus.yValid)    idle_d = '0;
        else if (idle_q != TW'(TIMEOUT)) idle_d = idle_q + 1'b1;
      end
      SCAN: begin
        s_d    = s_q + 1'b1;
        xcum_d = x_cum_next;
        ycum_d = y_cum_next;
        if (x_hit && !xfound_q) begin
          xfound_d    = 1'b1;
          xmed_scan_d = 8'(s_q);
        end
        if (y_hit && !yfound_q) begin
          yfound_d    = 1'b1;
          ymed_scan_d = 8'(s_q);
        end
        if (scan_last) begin
          xmedian_d    = xmed_scan_d;
          ymedian_d    = ymed_scan_d;
          hist_empty_d = (xtotal_q == '0);
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      nx_q         <= '0;
      ny_q         <= '0;
      s_q          <= '0;
      idle_q       <= '0;
      xtotal_q     <= '0;
      ytotal_q     <= '0;
      xcum_q       <= '0;
      ycum_q       <= '0;
      xfound_q     <= 1'b0;
      yfound_q     <= 1'b0;
      xmed_scan_q  <= '0;
      ymed_scan_q  <= '0;
      xmedian_q    <= '0;
      ymedian_q    <= '0;
      hist_empty_q <= 1'b0;
    end else begin
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      s_q          <= s_d;
      idle_q       <= idle_d;
      xtotal_q     <= xtotal_d;
      ytotal_q     <= ytotal_d;
      xcum_q       <= xcum_d;
      ycum_q       <= ycum_d;
      xfound_q     <= xfound_d;
      yfound_q     <= yfound_d;
      xmed_scan_q  <= xmed_scan_d;
      ymed_scan_q  <= ymed_scan_d;
      xmedian_q    <= xmedian_d;
      ymedian_q    <= ymedian_d;
      hist_empty_q <= hist_empty_d;
    end
  end

  // NOTE: the bin buffers have no reset; nothing reads past nx/ny, so their
  // contents never need a known value and they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (x_store) xbuf_q[nx_q] <= bus.xHistogramIn;
    if (y_store) ybuf_q[ny_q] <= bus.yHistogramIn;
  end

  assign bus.readHistogram = read_hist;
  assign bus.medianValid   = median_valid;
  assign bus.busy          = busy;
  assign bus.xMedian       = xmedian_q;
  assign bus.yMedian       = ymedian_q;
  assign bus.histEmpty     = hist_empty_q;

endmodule

// File: tb/tb_histogram_median.sv
// Directed bench for histogram_median: streams hand-built histograms and
// compares the reported medians, flags and timing against worked-out values.
module tb_histogram_median;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  histogram_median_if #(.BINW(8)) bus ();

  histogram_median #(
    .IMWIDTH (240),
    .IMHEIGHT(180),
    .BINW    (8),
    .SUMW    (16),
    .TIMEOUT (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] xb [256];
  logic [7:0] yb [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_bins();
    for (int i = 0; i < 256; i++) begin
      xb[i] = 8'd0;
      yb[i] = 8'd0;
    end
  endtask

  // Starts a computation and streams xb[0:xlen-1] / yb[0:ylen-1]. With abort
  // set, reset is pulsed mid-SCAN instead of waiting for the result.
  task automatic run_frame(input int xlen, input int ylen, input bit xgap, input bit ygap,
                           input bit poke, input bit abort, output int lat);
    int xi, yi, xg, yg, cyc;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("req_pulse", bus.readHistogram, 1);
    check("req_busy", bus.busy, 1);
    @(negedge clk);
    xi = 0; yi = 0; xg = 0; yg = 0; cyc = 0;
    while (xi < xlen || yi < ylen) begin
      if (xi < xlen && xg == 0) begin
        bus.xValid = 1'b1;
        bus.xHistogramIn = xb[xi];
        xi++;
        if (xgap) xg = $urandom_range(3, 0);
      end else begin
        bus.xValid = 1'b0;
        if (xg > 0) xg--;
      end
      if (yi < ylen && yg == 0) begin
        bus.yValid = 1'b1;
        bus.yHistogramIn = yb[yi];
        yi++;
        if (ygap) yg = $urandom_range(3, 0);
      end else begin
        bus.yValid = 1'b0;
        if (yg > 0) yg--;
      end
      bus.start = poke && (cyc == 3);
      @(negedge clk);
      if (poke && cyc == 3) begin
        check("start_while_busy_no_req", bus.readHistogram, 0);
        check("start_while_busy_busy", bus.busy, 1);
      end
      cyc++;
    end
    bus.xValid = 1'b0;
    bus.yValid = 1'b0;
    bus.start  = 1'b0;
    lat = 0;
    if (abort) begin
      repeat (50) @(negedge clk);
      check("scan_busy", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_no_valid", bus.medianValid, 0);
      check("abort_not_busy", bus.busy, 0);
      seen = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (bus.medianValid === 1'b1) seen = 1'b1;
      end
      check("abort_no_late_valid", seen, 0);
    end else begin
      while (bus.medianValid !== 1'b1 && lat < 2000) begin
        @(negedge clk);
        lat++;
      end
      check("median_valid_seen", bus.medianValid, 1);
    end
  endtask

  // Called in the medianValid cycle.
  task automatic check_result(input string tag, input int xm, input int ym, input bit he);
    check({tag, "_xmedian"}, bus.xMedian, xm);
    check({tag, "_ymedian"}, bus.yMedian, ym);
    check({tag, "_empty"}, bus.histEmpty, he);
    check({tag, "_busy_done"}, bus.busy, 1);
    @(negedge clk);
    check({tag, "_valid_pulse"}, bus.medianValid, 0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.xValid = 1'b0;
    bus.yValid = 1'b0;
    bus.xHistogramIn = '0;
    bus.yHistogramIn = '0;
    repeat (3) @(negedge clk);
    check("rst_read", bus.readHistogram, 0);
    check("rst_valid", bus.medianValid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_empty", bus.histEmpty, 0);
    check("rst_xmedian", bus.xMedian, 0);
    check("rst_ymedian", bus.yMedian, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single event: last beat is x bin 239; result 241 cycles later.
    clear_bins();
    xb[100] = 8'd1;
    yb[50]  = 8'd1;
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check("single_latency", lat, 241);
    check_result("single", 100, 50, 0);

    // Even split resolves to the lower index; one more count tips it.
    clear_bins();
    xb[10]  = 8'd5;
    xb[200] = 8'd5;
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check_result("tie", 10, 0, 0);
    xb[200] = 8'd6;
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check_result("tie_tip", 200, 0, 0);

    clear_bins();
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check_result("empty", 0, 0, 1);

    // Full-scale bins: 2*255*(s+1) >= 61200 -> s=119; >= 45900 -> s=89.
    for (int i = 0; i < 240; i++) xb[i] = 8'd255;
    for (int i = 0; i < 180; i++) yb[i] = 8'd255;
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check_result("full", 119, 89, 0);

    clear_bins();
    xb[10]  = 8'd5;
    xb[200] = 8'd6;
    yb[50]  = 8'd1;
    run_frame(240, 180, 1, 0, 0, 0, lat);
    check_result("gappy", 200, 50, 0);

    // y stops at 100 bins; the timeout closes the capture.
    clear_bins();
    xb[5]  = 8'd1;
    yb[20] = 8'd3;
    yb[90] = 8'd3;
    run_frame(240, 100, 0, 0, 0, 0, lat);
    check_result("truncated", 5, 20, 0);

    // Ten extra x beats of 255 arrive while y is still streaming.
    clear_bins();
    xb[30] = 8'd2;
    for (int i = 240; i < 250; i++) xb[i] = 8'd255;
    yb[179] = 8'd4;
    run_frame(250, 180, 0, 1, 0, 0, lat);
    check_result("extra_beats", 30, 179, 0);

    // start during CAPTURE and during DONE are both ignored.
    clear_bins();
    xb[7] = 8'd1;
    yb[8] = 8'd1;
    run_frame(240, 180, 0, 0, 1, 0, lat);
    check("ctrl_xmedian", bus.xMedian, 7);
    check("ctrl_ymedian", bus.yMedian, 8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_in_done_no_req", bus.readHistogram, 0);
    check("start_in_done_idle", bus.busy, 0);
    @(negedge clk);
    check("start_in_done_still_idle", bus.readHistogram, 0);

    // Reset during SCAN, then a clean frame afterwards.
    clear_bins();
    xb[3] = 8'd1;
    yb[4] = 8'd1;
    run_frame(240, 180, 0, 0, 0, 1, lat);
    check("abort_xmedian_reset", bus.xMedian, 0);
    run_frame(240, 180, 0, 0, 0, 0, lat);
    check("recover_latency", lat, 241);
    check_result("recover", 3, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
